chan_responder: RTL and testbench

//  Dispatcher-side responder for CPU channel traffic. Receives CPU_R_CHAN_SET requests (post/get), keeps a small

---
 rtl/chan_responder_if.sv | 30 +++
 rtl/chan_responder.sv | 168 ++++++++++++++++
 tb/tb_chan_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chan_responder_if.sv
// Request/reply bus between the CPU message side and the channel responder.
// master = CPU side issuing channel requests, slave = responder.
interface chan_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MSG_W  = 8
);
    logic              cpu_msg_pulse;
    logic [MSG_W-1:0]  cpu_msg_in;
    logic              chan_msg_strb_i;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;

    logic              is_bus_busy;
    logic [MSG_W-1:0]  cpu_msg_out;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              chan_msg_strb_o;
    logic              ovf;

    modport master (
        output cpu_msg_pulse, cpu_msg_in, chan_msg_strb_i, addr_in, data_in,
        input  is_bus_busy, cpu_msg_out, addr_out, data_out, chan_msg_strb_o, ovf
    );

    modport slave (
        input  cpu_msg_pulse, cpu_msg_in, chan_msg_strb_i, addr_in, data_in,
        output is_bus_busy, cpu_msg_out, addr_out, data_out, chan_msg_strb_o, ovf
    );
endinterface

// File: rtl/chan_responder.sv
// Channel mailbox responder: matches channel posts with gets through a small
// table of per-address mailboxes and returns a one-cycle reply strobe.
module chan_responder #(
    parameter int               CHAN_NUM      = 4,
    parameter int               ADDR_W        = 32,
    parameter int               DATA_W        = 32,
    parameter int               MSG_W         = 8,
    parameter logic [MSG_W-1:0] CHAN_SET_CODE = MSG_W'(8'h0C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_oe,
    chan_responder_if.slave  bus
);
    localparam int IDX_W = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;

    typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, REPLY} state_t;

    typedef struct packed {
        logic              used;
        logic [ADDR_W-1:0] addr;
        logic              full;
        logic [DATA_W-1:0] data;
        logic              waiter;
    } entry_t;

    entry_t            mbox [CHAN_NUM];
    state_t            state;
    logic              req_post;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] reply_data;
    logic [IDX_W-1:0]  slot;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;

    // Scanning from the top down leaves the lowest matching index in each result.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = CHAN_NUM - 1; i >= 0; i--) begin
            if (mbox[i].used && mbox[i].addr == req_addr) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!mbox[i].used) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(negedge clk) begin
        if (!clk_oe) begin
            bus.chan_msg_strb_o <= 1'b0;
            bus.cpu_msg_out     <= '0;
            bus.addr_out        <= '0;
            bus.data_out        <= '0;
        end else if (rst) begin
            state               <= IDLE;
            bus.is_bus_busy     <= 1'b0;
            bus.chan_msg_strb_o <= 1'b0;
            bus.cpu_msg_out     <= '0;
            bus.addr_out        <= '0;
            bus.data_out        <= '0;
            bus.ovf             <= 1'b0;
            // NOTE: only the control bits of the table are reset; addr/data are
            // don't-care while used=0, so they stay plain storage.
            for (int i = 0; i < CHAN_NUM; i++) begin
                mbox[i].used   <= 1'b0;
                mbox[i].full   <= 1'b0;
                mbox[i].waiter <= 1'b0;
            end
        end else begin
            bus.chan_msg_strb_o <= 1'b0;
            bus.cpu_msg_out     <= '0;
            bus.addr_out        <= '0;
            bus.data_out        <= '0;

            case (state)
                IDLE: begin
                    if (bus.cpu_msg_pulse && bus.cpu_msg_in == CHAN_SET_CODE) begin
                        req_post        <= bus.chan_msg_strb_i;
                        req_addr        <= bus.addr_in;
                        req_data        <= bus.data_in;
                        state           <= LOOKUP;
                        bus.is_bus_busy <= 1'b1;
                    end
                end

                LOOKUP: begin
                    // Default is a drop straight back to IDLE.
                    state           <= IDLE;
                    bus.is_bus_busy <= 1'b0;
                    if (hit) begin
                        slot <= hit_idx;
                        if (req_post) begin
                            if (mbox[hit_idx].full) begin
                                bus.ovf <= 1'b1;
                            end else if (mbox[hit_idx].waiter) begin
                                reply_data      <= req_data;
                                state           <= REPLY;
                                bus.is_bus_busy <= 1'b1;
                            end else begin
                                state           <= UPDATE;
                                bus.is_bus_busy <= 1'b1;
                            end
                        end else begin
                            if (mbox[hit_idx].full) begin
                                reply_data      <= mbox[hit_idx].data;
                                state           <= REPLY;
                                bus.is_bus_busy <= 1'b1;
                            end else if (mbox[hit_idx].waiter) begin
                                bus.ovf <= 1'b1;
                            end else begin
                                state           <= UPDATE;
                                bus.is_bus_busy <= 1'b1;
                            end
                        end
                    end else if (free_found) begin
                        slot            <= free_idx;
                        state           <= UPDATE;
                        bus.is_bus_busy <= 1'b1;
                    end else begin
                        bus.ovf <= 1'b1;
                    end
                end

                UPDATE: begin
                    mbox[slot].used <= 1'b1;
                    mbox[slot].addr <= req_addr;
                    if (req_post) begin
                        mbox[slot].full <= 1'b1;
                        mbox[slot].data <= req_data;
                    end else begin
                        mbox[slot].waiter <= 1'b1;
                    end
                    state           <= IDLE;
                    bus.is_bus_busy <= 1'b0;
                end

                REPLY: begin
                    bus.chan_msg_strb_o <= 1'b1;
                    bus.cpu_msg_out     <= CHAN_SET_CODE;
                    bus.addr_out        <= req_addr;
                    bus.data_out        <= reply_data;
                    // A reply always consumes both the value and the waiter.
                    mbox[slot].used     <= 1'b0;
                    mbox[slot].full     <= 1'b0;
                    mbox[slot].waiter   <= 1'b0;
                    state               <= IDLE;
                    bus.is_bus_busy     <= 1'b0;
                end

                default: begin
                    state           <= IDLE;
                    bus.is_bus_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_chan_responder.sv
// Directed bench for chan_responder: post/get matching, waiters, overflow,
// busy/ignored requests, reset mid-reply and clk_oe gating.
module tb_chan_responder;
    localparam logic [7:0] CODE  = 8'h0C;
    localparam logic [7:0] OTHER = 8'h03;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_oe = 1'b1;

    int passed = 0;
    int total  = 0;

    chan_responder_if bus ();

    chan_responder #(
        .CHAN_NUM     (4),
        .ADDR_W       (32),
        .DATA_W       (32),
        .MSG_W        (8),
        .CHAN_SET_CODE(CODE)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clk_oe(clk_oe),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The DUT updates on negedge; the bench drives and samples just after posedge.
    task automatic idle_inputs();
        bus.cpu_msg_pulse   = 1'b0;
        bus.cpu_msg_in      = '0;
        bus.chan_msg_strb_i = 1'b0;
        bus.addr_in         = '0;
        bus.data_in         = '0;
    endtask

    task automatic drive_req(input bit post, input logic [31:0] a,
                             input logic [31:0] d, input logic [7:0] code);
        bus.cpu_msg_pulse   = 1'b1;
        bus.cpu_msg_in      = code;
        bus.chan_msg_strb_i = post;
        bus.addr_in         = a;
        bus.data_in         = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
    endtask

    // One request, then four edges of observation (sample edge = lat 0).
    task automatic req(input bit post, input logic [31:0] a, input logic [31:0] d,
                       input logic [7:0] code, output int nstrb, output int lat,
                       output logic [31:0] ra, output logic [31:0] rd,
                       output logic [7:0] rc);
        drive_req(post, a, d, code);
        @(posedge clk);
        idle_inputs();
        nstrb = 0;
        lat   = -1;
        ra    = '0;
        rd    = '0;
        rc    = '0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            if (bus.chan_msg_strb_o === 1'b1) begin
                nstrb++;
                if (lat < 0) begin
                    lat = k;
                    ra  = bus.addr_out;
                    rd  = bus.data_out;
                    rc  = bus.cpu_msg_out;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        clk_oe = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        rst = 1'b0;
        total++; if (bus.is_bus_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.is_bus_busy); else passed++;
        total++; if (bus.chan_msg_strb_o !== 1'b0) $display("FAIL reset_strb: got %b expected 0", bus.chan_msg_strb_o); else passed++;
        total++; if (bus.cpu_msg_out !== 8'h00) $display("FAIL reset_msg: got %h expected 00", bus.cpu_msg_out); else passed++;
        total++; if (bus.addr_out !== 32'h0) $display("FAIL reset_addr: got %h expected 0", bus.addr_out); else passed++;
        total++; if (bus.data_out !== 32'h0) $display("FAIL reset_data: got %h expected 0", bus.data_out); else passed++;
        total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", bus.ovf); else passed++;
    endtask

    task automatic test_post_get();
        int n, lat;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        req(1'b1, 32'h100, 32'h55, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL post_no_reply: got %0d strobes expected 0", n); else passed++;
        req(1'b0, 32'h100, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 1) $display("FAIL get_strobes: got %0d expected 1", n); else passed++;
        total++; if (lat !== 2) $display("FAIL get_latency: got %0d expected 2", lat); else passed++;
        total++; if (ra !== 32'h100) $display("FAIL get_addr: got %h expected 100", ra); else passed++;
        total++; if (rd !== 32'h55) $display("FAIL get_data: got %h expected 55", rd); else passed++;
        total++; if (rc !== CODE) $display("FAIL get_code: got %h expected %h", rc, CODE); else passed++;
        total++; if (bus.addr_out !== 32'h0 || bus.data_out !== 32'h0 || bus.cpu_msg_out !== 8'h0)
            $display("FAIL post_reply_idle: got addr %h data %h msg %h expected all 0", bus.addr_out, bus.data_out, bus.cpu_msg_out);
        else passed++;
        // Entry must be freed: a second get becomes a waiter with no reply.
        req(1'b0, 32'h100, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL get_after_free: got %0d strobes expected 0", n); else passed++;
        total++; if (bus.ovf !== 1'b0) $display("FAIL post_get_ovf: got %b expected 0", bus.ovf); else passed++;
    endtask

    task automatic test_waiter();
        int n, lat;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        req(1'b0, 32'h200, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL waiter_get_no_reply: got %0d expected 0", n); else passed++;
        req(1'b1, 32'h200, 32'hAB, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 1) $display("FAIL waiter_strobes: got %0d expected 1", n); else passed++;
        total++; if (lat !== 2) $display("FAIL waiter_latency: got %0d expected 2", lat); else passed++;
        total++; if (ra !== 32'h200) $display("FAIL waiter_addr: got %h expected 200", ra); else passed++;
        total++; if (rd !== 32'hAB) $display("FAIL waiter_data: got %h expected ab", rd); else passed++;
        req(1'b0, 32'h200, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL waiter_entry_freed: got %0d expected 0", n); else passed++;
        // A second waiter on the same address is dropped.
        req(1'b0, 32'h200, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b1) $display("FAIL double_waiter_ovf: got %b expected 1", bus.ovf); else passed++;
    endtask

    task automatic test_double_post();
        int n, lat;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        req(1'b1, 32'h300, 32'h11, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b0) $display("FAIL dpost_first_ovf: got %b expected 0", bus.ovf); else passed++;
        req(1'b1, 32'h300, 32'h22, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b1) $display("FAIL dpost_second_ovf: got %b expected 1", bus.ovf); else passed++;
        total++; if (n !== 0) $display("FAIL dpost_no_reply: got %0d expected 0", n); else passed++;
        req(1'b0, 32'h300, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 1 || rd !== 32'h11) $display("FAIL dpost_get: got %0d strobes data %h expected 1 strobe data 11", n, rd); else passed++;
        total++; if (bus.ovf !== 1'b1) $display("FAIL dpost_ovf_sticky: got %b expected 1", bus.ovf); else passed++;
    endtask

    task automatic test_table_full();
        int n, lat;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        for (int i = 0; i < 4; i++) req(1'b1, 32'h400 + i, 32'hA0 + i, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b0) $display("FAIL full_four_ovf: got %b expected 0", bus.ovf); else passed++;
        req(1'b1, 32'h404, 32'hEE, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b1) $display("FAIL full_fifth_ovf: got %b expected 1", bus.ovf); else passed++;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 32'h400 + i, 32'h0, CODE, n, lat, ra, rd, rc);
            total++;
            if (n !== 1 || ra !== 32'h400 + i || rd !== 32'hA0 + i)
                $display("FAIL full_get%0d: got %0d strobes addr %h data %h expected 1 addr %h data %h",
                         i, n, ra, rd, 32'h400 + i, 32'hA0 + i);
            else passed++;
        end
        req(1'b0, 32'h404, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL full_fifth_not_stored: got %0d strobes expected 0", n); else passed++;
    endtask

    task automatic test_ignored();
        int n, lat, cnt;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        drive_req(1'b1, 32'h500, 32'h5A, CODE);
        @(posedge clk);
        total++; if (bus.is_bus_busy !== 1'b1) $display("FAIL busy_after_accept: got %b expected 1", bus.is_bus_busy); else passed++;
        // Get while busy (LOOKUP then UPDATE) must be ignored.
        drive_req(1'b0, 32'h500, 32'h0, CODE);
        cnt = 0;
        repeat (2) begin
            @(posedge clk);
            if (bus.chan_msg_strb_o === 1'b1) cnt++;
        end
        idle_inputs();
        repeat (4) begin
            @(posedge clk);
            if (bus.chan_msg_strb_o === 1'b1) cnt++;
        end
        total++; if (cnt !== 0) $display("FAIL busy_get_ignored: got %0d strobes expected 0", cnt); else passed++;
        req(1'b0, 32'h500, 32'h0, OTHER, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL other_code_ignored: got %0d strobes expected 0", n); else passed++;
        req(1'b0, 32'h500, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 1 || rd !== 32'h5A) $display("FAIL ignored_table_kept: got %0d strobes data %h expected 1 data 5a", n, rd); else passed++;
        total++; if (bus.ovf !== 1'b0) $display("FAIL ignored_ovf: got %b expected 0", bus.ovf); else passed++;
    endtask

    task automatic test_reset_in_reply();
        int n, lat, cnt;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        req(1'b1, 32'h600, 32'h66, CODE, n, lat, ra, rd, rc);
        req(1'b1, 32'h600, 32'h67, CODE, n, lat, ra, rd, rc);
        total++; if (bus.ovf !== 1'b1) $display("FAIL rr_pre_ovf: got %b expected 1", bus.ovf); else passed++;
        drive_req(1'b0, 32'h600, 32'h0, CODE);
        @(posedge clk);
        idle_inputs();
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        total++; if (bus.chan_msg_strb_o !== 1'b0 || bus.cpu_msg_out !== 8'h0 || bus.addr_out !== 32'h0 || bus.data_out !== 32'h0)
            $display("FAIL rr_outputs: got strb %b msg %h addr %h data %h expected all 0",
                     bus.chan_msg_strb_o, bus.cpu_msg_out, bus.addr_out, bus.data_out);
        else passed++;
        total++; if (bus.is_bus_busy !== 1'b0 || bus.ovf !== 1'b0)
            $display("FAIL rr_busy_ovf: got busy %b ovf %b expected 0 0", bus.is_bus_busy, bus.ovf);
        else passed++;
        cnt = 0;
        repeat (3) begin
            @(posedge clk);
            if (bus.chan_msg_strb_o === 1'b1) cnt++;
        end
        total++; if (cnt !== 0) $display("FAIL rr_no_late_strobe: got %0d expected 0", cnt); else passed++;
        req(1'b0, 32'h600, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL rr_table_cleared: got %0d strobes expected 0", n); else passed++;
    endtask

    task automatic test_clk_oe();
        int n, lat;
        logic [31:0] ra, rd;
        logic [7:0] rc;
        do_reset();
        clk_oe = 1'b0;
        drive_req(1'b1, 32'h610, 32'h61, CODE);
        @(posedge clk);
        idle_inputs();
        clk_oe = 1'b1;
        total++; if (bus.is_bus_busy !== 1'b0) $display("FAIL oe_req_busy: got %b expected 0", bus.is_bus_busy); else passed++;
        req(1'b0, 32'h610, 32'h0, CODE, n, lat, ra, rd, rc);
        total++; if (n !== 0) $display("FAIL oe_post_dropped: got %0d strobes expected 0", n); else passed++;

        // Gate the REPLY edge: reply must slip by one enabled edge.
        do_reset();
        req(1'b1, 32'h620, 32'h62, CODE, n, lat, ra, rd, rc);
        drive_req(1'b0, 32'h620, 32'h0, CODE);
        @(posedge clk);
        idle_inputs();
        @(posedge clk);
        clk_oe = 1'b0;
        @(posedge clk);
        total++; if (bus.chan_msg_strb_o !== 1'b0 || bus.cpu_msg_out !== 8'h0)
            $display("FAIL oe_gated_strobe: got strb %b msg %h expected 0 00", bus.chan_msg_strb_o, bus.cpu_msg_out);
        else passed++;
        total++; if (bus.is_bus_busy !== 1'b1) $display("FAIL oe_gated_hold: got busy %b expected 1", bus.is_bus_busy); else passed++;
        clk_oe = 1'b1;
        @(posedge clk);
        total++; if (bus.chan_msg_strb_o !== 1'b1 || bus.addr_out !== 32'h620 || bus.data_out !== 32'h62)
            $display("FAIL oe_resumed_reply: got strb %b addr %h data %h expected 1 620 62",
                     bus.chan_msg_strb_o, bus.addr_out, bus.data_out);
        else passed++;
        @(posedge clk);
        total++; if (bus.chan_msg_strb_o !== 1'b0 || bus.is_bus_busy !== 1'b0)
            $display("FAIL oe_reply_done: got strb %b busy %b expected 0 0", bus.chan_msg_strb_o, bus.is_bus_busy);
        else passed++;
    endtask

    initial begin
        idle_inputs();
        @(posedge clk);
        test_reset();
        test_post_get();
        test_waiter();
        test_double_post();
        test_table_full();
        test_ignored();
        test_reset_in_reply();
        test_clk_oe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
